wbs_router: RTL

Single-master to multi-slave Wishbone router sitting directly downstream of the master arbiter. It takes the arbitrated 16-bit address/16-bit data bus and decodes the address against per-slave ranges. It forwards each request to exactly one slave with the address rebased to that slave's window, and returns ack/data. Unmapped addresses and silent slaves are turned into a bus error so the upstream master never hangs.

---
 rtl/wbs_router.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wbs_router.sv
// wbs_router: single-master to multi-slave Wishbone router.
// Decodes the arbitrated address against per-slave inclusive ranges (lowest
// index wins). It forwards a one-cycle strobe with the address rebased into the
// slave's window, and returns ack/data. An unmapped address, a slave error or a
// silent slave is reported upstream as a one-cycle bus error.
module wbs_router #(
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*16-1:0] SLAVE_ADDR = {16'h3000, 16'h2000, 16'h1000, 16'h0000},
  parameter logic [NUM_SLAVES*16-1:0] SLAVE_HIGH = {16'h3fff, 16'h2fff, 16'h1fff, 16'h0fff},
  parameter int TIMEOUT = 1000,
  parameter int TO_BITS = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wbm_cyc_i,
  input  logic                     wbm_stb_i,
  input  logic                     wbm_we_i,
  input  logic [15:0]              wbm_adr_i,
  input  logic [15:0]              wbm_dat_i,
  output logic [15:0]              wbm_dat_o,
  output logic                     wbm_ack_o,
  output logic                     wbm_err_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [15:0]              wbs_adr_o,
  output logic [15:0]              wbs_dat_o,
  input  logic [NUM_SLAVES*16-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  input  logic [NUM_SLAVES-1:0]    wbs_err_i
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state_reg;
  logic [SEL_W-1:0]     sel_reg;
  logic [TO_BITS-1:0]   count_reg;

  logic [NUM_SLAVES-1:0] match;
  logic                  hit;
  logic [SEL_W-1:0]      hit_idx;
  logic [15:0]           hit_base;
  logic                  sel_ack;
  logic                  sel_err;
  logic [15:0]           sel_dat;

  // Per-slave inclusive range comparison on the incoming address.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign match[gi] = (wbm_adr_i >= SLAVE_ADDR[16*gi +: 16]) &&
                         (wbm_adr_i <= SLAVE_HIGH[16*gi +: 16]);
    end
  endgenerate

  // Priority pick: scanning downward lets the lowest matching index overwrite.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int n = NUM_SLAVES - 1; n >= 0; n--) begin
      if (match[n]) begin
        hit      = 1'b1;
        hit_idx  = SEL_W'(n);
        hit_base = SLAVE_ADDR[16*n +: 16];
      end
    end
  end

  // Only the selected slave's response lines are visible to the FSM.
  always_comb begin
    sel_ack = wbs_ack_i[sel_reg];
    sel_err = wbs_err_i[sel_reg];
    sel_dat = wbs_dat_i[16*sel_reg +: 16];
  end

  // Request/response FSM with fully registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      count_reg <= '0;
      wbs_cyc_o <= '0;
      wbs_stb_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
    end else begin
      // Strobe and completion flags are single-cycle pulses by default.
      wbs_cyc_o <= '0;
      wbs_stb_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wbm_cyc_i && wbm_stb_i) begin
            wbs_we_o  <= wbm_we_i;
            wbs_dat_o <= wbm_dat_i;
            if (hit) begin
              wbs_cyc_o <= NUM_SLAVES'(1) << hit_idx;
              wbs_stb_o <= NUM_SLAVES'(1) << hit_idx;
              wbs_adr_o <= wbm_adr_i - hit_base;
              sel_reg   <= hit_idx;
              count_reg <= '0;
              state_reg <= WAIT;
            end else begin
              // Nothing decodes: keep the raw address and fail immediately.
              wbs_adr_o <= wbm_adr_i;
              wbm_err_o <= 1'b1;
            end
          end
        end
        WAIT: begin
          // A real response beats the timeout; err beats ack.
          if (sel_err) begin
            wbm_err_o <= 1'b1;
            state_reg <= IDLE;
          end else if (sel_ack) begin
            wbm_dat_o <= sel_dat;
            wbm_ack_o <= 1'b1;
            state_reg <= IDLE;
          end else if (count_reg == TO_LIMIT) begin
            wbm_err_o <= 1'b1;
            state_reg <= IDLE;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
